back_bar_stretch: RTL and testbench
===================================

Name: back_bar_stretch

Overview:
- Conditions the 28 raw back-wall bar discriminator signals before they reach the 18-region back-wall OR stage of the MUSE PID trigger.
- Per channel it does three things:
  - synchronizes the asynchronous input to clk;
  - detects the rising edge;
  - emits a fixed-width stretched pulse, followed by a programmable dead time.
- The 28-bit back_out bus connects bit-for-bit to the back-wall OR stage input.

Parameters:
- N_CH, 28, number of back-wall bar channels.
- CW, 6, width of the pulse-width and dead-time configuration fields and of the per-channel counters.
- RETRIGGER, 1, 1 = an edge during ACTIVE reloads the width counter; 0 = the edge is ignored.

Ports:
- clk  input  1  trigger clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- bar_in  input  N_CH  raw discriminator levels, asynchronous to clk.
- inhibit  input  1  synchronous; while high, new edges are not accepted.
- width_cfg  input  CW  stretched pulse width in clk cycles; 0 is treated as 1.
- dead_cfg  input  CW  dead-time length in clk cycles; 0 means no dead time.
- back_out  output  N_CH  stretched hits, registered; feeds the back-wall OR stage.
- active_any  output  1  combinational OR of back_out.
- edge_cnt  output  16  saturating count of accepted edges across all channels.

Behaviour:
- Reset (reset_n low at a clk edge):
  - sync FFs, edge-detect FFs and counters cleared;
  - all channels go to IDLE;
  - back_out = 0 and edge_cnt = 0.
  - Reset takes priority over every other event, including mid-pulse: the output drops on the next edge.
- Synchronizer: 2 FFs per channel (meta, sync), then prev. edge = sync & ~prev.
  - A level held high through reset release produces exactly one edge.
- Latency: back_out rises on the 3rd clk edge counting the first edge that samples bar_in high. Edges 0/1 are synchronization; the state load occurs on edge 2.
- Per-channel FSM:
  - IDLE:
    - on an accepted edge: load cnt = max(width_cfg,1)-1, back_out=1, go ACTIVE.
  - ACTIVE:
    - if cnt != 0: cnt-1.
    - if cnt == 0 and dead_cfg != 0: load cnt = dead_cfg-1, back_out=0, go DEAD.
    - if cnt == 0 and dead_cfg == 0: back_out=0, go IDLE.
    - back_out is high for exactly max(width_cfg,1) cycles.
    - RETRIGGER=1 and an accepted edge in ACTIVE (including the last cycle): reload the width count and stay ACTIVE with no low gap. That edge counts toward edge_cnt.
    - RETRIGGER=0: the edge is ignored and not counted.
  - DEAD:
    - back_out=0; edges ignored and not counted.
    - cnt reaches 0: go IDLE. An edge on the cycle after entering IDLE is accepted.
- Accepted edge = edge & ~inhibit & (state permits).
  - inhibit does not truncate pulses in progress; it only blocks new loads and reloads.
- width_cfg and dead_cfg are sampled only at load time. Changing them mid-pulse does not alter the running count.
- edge_cnt:
  - adds the number of channels accepting an edge this cycle (0..N_CH, popcount);
  - saturates at 16'hFFFF and never wraps;
  - updates 1 cycle after the accepted edge, i.e. in step with back_out rising.
- Channels are fully independent. Simultaneous edges on all 28 channels are legal: +28 to edge_cnt in one cycle.

Decomposition:
- Shared package trig_pkg:
  - state enum {IDLE, ACTIVE, DEAD};
  - constants N_BACK=28, CFG_W=6, CNT16_MAX.
- Sub-module back_chan_stretch: one channel (sync, edge detect, FSM, counter), with outputs back_out bit and accept strobe.
- The top instantiates N_CH copies via generate and does the popcount/saturating counter plus active_any.

Test Plan:
- Reset, then bar_in[5] high for 1 cycle, width_cfg=4, dead_cfg=3: back_out[5] high on edges 2..5, low for 3 cycles, then re-armable; edge_cnt=1.
- Second pulse on ch5 during DEAD: no output, edge_cnt stays 1. Second pulse 1 cycle after DEAD ends: accepted, edge_cnt=2.
- RETRIGGER=1, width_cfg=4, ch0 edges 2 cycles apart: back_out[0] continuous for 2+4=6 cycles, edge_cnt=2. Repeat with RETRIGGER=0: 4 cycles, edge_cnt=1.
- All 28 channels edge in the same cycle with inhibit=0: back_out=28'hFFFFFFF, active_any=1, edge_cnt=28. Same with inhibit=1: back_out stays 0, edge_cnt unchanged.
- width_cfg=0, dead_cfg=0: 1-cycle output pulses. An input toggling every 4 cycles gives one pulse per rising edge. Force edge_cnt near 16'hFFFF: it saturates, no wrap.
- reset_n low mid-ACTIVE on ch27: back_out[27]=0 next edge. bar_in[27] held high through release: exactly one pulse follows.

Source files
------------

// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
//  trig_pkg
//  Shared types and constants for the MUSE PID trigger back-wall path.
//  Revision: 1.0
// ============================================================================
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DEAD   = 2'd2
    } chan_state_t;

    localparam int          N_BACK    = 28;
    localparam int          CFG_W     = 6;
    localparam logic [15:0] CNT16_MAX = 16'hFFFF;

    // Adds b to a, clamping at CNT16_MAX instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? CNT16_MAX : sum[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/back_chan_stretch.sv
`default_nettype none
// ============================================================================
//  back_chan_stretch
//  One back-wall bar: 2-FF synchronizer, rising-edge detect, stretch + dead time.
//  Revision: 1.0
// ============================================================================
module back_chan_stretch
    import trig_pkg::*;
#(
    parameter int CW        = CFG_W,
    parameter bit RETRIGGER = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          bar_in,
    input  logic          inhibit,
    input  logic [CW-1:0] width_cfg,
    input  logic [CW-1:0] dead_cfg,
    output logic          back_out,
    output logic          accept
);

    logic          meta;
    logic          sync;
    logic          prev;
    logic          rise;
    logic          can_load;
    logic [CW-1:0] width_load;
    logic [CW-1:0] cnt;
    chan_state_t   state;

    always_comb begin
        rise       = sync & ~prev;
        can_load   = (state == IDLE) || (RETRIGGER && (state == ACTIVE));
        accept     = rise & ~inhibit & can_load;
        // A zero width still yields a one-cycle pulse.
        width_load = (width_cfg == '0) ? '0 : (width_cfg - CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            prev     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
            back_out <= 1'b0;
        end else begin
            meta <= bar_in;
            sync <= meta;
            prev <= sync;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= width_load;
                        back_out <= 1'b1;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        cnt <= width_load;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (dead_cfg != '0) begin
                        cnt      <= dead_cfg - CW'(1);
                        back_out <= 1'b0;
                        state    <= DEAD;
                    end else begin
                        back_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DEAD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    back_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/back_bar_stretch.sv
`default_nettype none
// ============================================================================
//  back_bar_stretch
//  Conditions the raw back-wall bar hits ahead of the back-wall OR stage.
//  Revision: 1.0
// ============================================================================
module back_bar_stretch
    import trig_pkg::*;
#(
    parameter int N_CH      = N_BACK,
    parameter int CW        = CFG_W,
    parameter bit RETRIGGER = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] bar_in,
    input  logic            inhibit,
    input  logic [CW-1:0]   width_cfg,
    input  logic [CW-1:0]   dead_cfg,
    output logic [N_CH-1:0] back_out,
    output logic            active_any,
    output logic [15:0]     edge_cnt
);

    logic [N_CH-1:0] accept;
    logic [15:0]     hits;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_chan
            back_chan_stretch #(
                .CW        (CW),
                .RETRIGGER (RETRIGGER)
            ) u_chan (
                .clk       (clk),
                .reset_n   (reset_n),
                .bar_in    (bar_in[i]),
                .inhibit   (inhibit),
                .width_cfg (width_cfg),
                .dead_cfg  (dead_cfg),
                .back_out  (back_out[i]),
                .accept    (accept[i])
            );
        end
    endgenerate

    // Number of channels accepting an edge this cycle.
    always_comb begin
        hits = '0;
        for (int i = 0; i < N_CH; i++) begin
            hits = hits + {15'd0, accept[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= sat_add16(edge_cnt, hits);
        end
    end

    assign active_any = |back_out;

endmodule
`default_nettype wire

// File: tb/tb_back_bar_stretch.sv
`default_nettype none
// ============================================================================
//  tb_back_bar_stretch
//  Bench for back_bar_stretch, RETRIGGER=1 and RETRIGGER=0 side by side.
//  Revision: 1.0
// ============================================================================
module tb_back_bar_stretch;

    localparam int NCH = 28;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           inhibit;
    logic [NCH-1:0] bar_in;
    logic [5:0]     width_cfg;
    logic [5:0]     dead_cfg;
    logic [NCH-1:0] bo1, bo0;
    logic           any1, any0;
    logic [15:0]    cnt1, cnt0;

    always #5 clk = ~clk;

    back_bar_stretch #(.N_CH(NCH), .CW(6), .RETRIGGER(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bar_in(bar_in), .inhibit(inhibit),
        .width_cfg(width_cfg), .dead_cfg(dead_cfg),
        .back_out(bo1), .active_any(any1), .edge_cnt(cnt1)
    );

    back_bar_stretch #(.N_CH(NCH), .CW(6), .RETRIGGER(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bar_in(bar_in), .inhibit(inhibit),
        .width_cfg(width_cfg), .dead_cfg(dead_cfg),
        .back_out(bo0), .active_any(any0), .edge_cnt(cnt0)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Timeline model: a pulse accepted at edge t is high after edges t..t+W-1,
    // the channel counts as ACTIVE up to edge t+W, and may re-arm D+1 edges later.
    int             t = 0;
    int             hi_end  [2][NCH];
    int             idle_at [2][NCH];
    logic [NCH-1:0] m_out [2];
    int             m_cnt [2];
    logic [NCH-1:0] h1, h2, h3, m_rise;
    int             m_n;
    bit             m_act, m_idle;
    bit             model_on = 0;

    always @(posedge clk) begin
        t++;
        if (!reset_n) begin
            h1 = '0; h2 = '0; h3 = '0;
            for (int v = 0; v < 2; v++) begin
                m_out[v] = '0;
                m_cnt[v] = 0;
                for (int ch = 0; ch < NCH; ch++) begin
                    hi_end[v][ch]  = -1;
                    idle_at[v][ch] = 0;
                end
            end
        end else begin
            m_rise = h2 & ~h3;
            for (int v = 0; v < 2; v++) begin
                m_n = 0;
                for (int ch = 0; ch < NCH; ch++) begin
                    m_act  = (t <= hi_end[v][ch]);
                    m_idle = !m_act && (t >= idle_at[v][ch]);
                    if (m_rise[ch] && !inhibit && (m_idle || (v == 1 && m_act))) begin
                        hi_end[v][ch] = t + ((width_cfg == 6'd0) ? 1 : int'(width_cfg));
                        m_n++;
                    end else if (t == hi_end[v][ch]) begin
                        idle_at[v][ch] = t + int'(dead_cfg) + 1;
                    end
                    m_out[v][ch] = (t < hi_end[v][ch]);
                end
                m_cnt[v] = (m_cnt[v] + m_n > 65535) ? 65535 : m_cnt[v] + m_n;
            end
            h3 = h2; h2 = h1; h1 = bar_in;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("out_rt1", bo1,  m_out[1]);
            check("cnt_rt1", cnt1, m_cnt[1]);
            check("any_rt1", any1, |m_out[1]);
            check("out_rt0", bo0,  m_out[0]);
            check("cnt_rt0", cnt0, m_cnt[0]);
            check("any_rt0", any0, |m_out[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
    endtask

    int hc1, hc0, pc, rises;
    bit prv;

    initial begin
        reset_n = 1'b0; inhibit = 1'b0; bar_in = '0;
        width_cfg = 6'd4; dead_cfg = 6'd3;
        do_reset();
        model_on = 1;
        check("reset_out", bo1, 0);
        check("reset_cnt", cnt1, 0);

        // Single hit on ch5: high on edges 2..5, then 3 dead cycles.
        bar_in[5] = 1'b1; tick(); bar_in[5] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t1_out5", bo1[5], (k >= 2 && k <= 5) ? 1 : 0);
        end
        check("t1_cnt", cnt1, 1);

        // Edge landing in DEAD is dropped; the one right after DEAD is kept.
        do_reset();
        bar_in[5] = 1'b1; tick(); bar_in[5] = 1'b0;
        ticks(4);
        bar_in[5] = 1'b1; tick(); bar_in[5] = 1'b0;
        ticks(2);
        check("t2_dead_out", bo1[5], 0);
        check("t2_dead_cnt", cnt1, 1);
        bar_in[5] = 1'b1; tick(); bar_in[5] = 1'b0;
        ticks(2);
        check("t2_rearm_out", bo1[5], 1);
        check("t2_rearm_cnt", cnt1, 2);

        // Retrigger: ch0 edges 2 cycles apart.
        do_reset();
        bar_in[0] = 1'b1; tick(); bar_in[0] = 1'b0; tick();
        bar_in[0] = 1'b1; tick(); bar_in[0] = 1'b0;
        hc1 = int'(bo1[0]); hc0 = int'(bo0[0]);
        for (int k = 0; k < 12; k++) begin
            tick();
            hc1 += int'(bo1[0]); hc0 += int'(bo0[0]);
        end
        check("t3_width_rt1", hc1, 6);
        check("t3_width_rt0", hc0, 4);
        check("t3_cnt_rt1", cnt1, 2);
        check("t3_cnt_rt0", cnt0, 1);

        // All channels at once, then again under inhibit.
        do_reset();
        bar_in = '1; tick(); bar_in = '0; ticks(2);
        check("t4_all_out", bo1, 28'hFFFFFFF);
        check("t4_all_any", any1, 1);
        check("t4_all_cnt", cnt1, 28);
        ticks(12);
        inhibit = 1'b1;
        bar_in = '1; tick(); bar_in = '0; ticks(2);
        check("t4_inh_out", bo1, 0);
        check("t4_inh_cnt", cnt1, 28);
        ticks(3);
        inhibit = 1'b0;

        // Zero width / zero dead: one 1-cycle pulse per rising edge.
        do_reset();
        width_cfg = 6'd0; dead_cfg = 6'd0; pc = 0;
        for (int p = 0; p < 5; p++) begin
            bar_in[3] = 1'b1; tick(); pc += int'(bo1[3]); tick(); pc += int'(bo1[3]);
            bar_in[3] = 1'b0; tick(); pc += int'(bo1[3]); tick(); pc += int'(bo1[3]);
        end
        for (int k = 0; k < 4; k++) begin
            tick(); pc += int'(bo1[3]);
        end
        check("t5_pulses", pc, 5);
        check("t5_cnt", cnt1, 5);

        // Saturation: 2400 edges on each of 28 channels exceeds 16'hFFFF.
        for (int i = 0; i < 2400; i++) begin
            bar_in = '1; tick(); bar_in = '0; tick();
        end
        ticks(4);
        check("t5_sat_rt1", cnt1, 16'hFFFF);
        check("t5_sat_rt0", cnt0, 16'hFFFF);

        // Reset mid-pulse on ch27, then a level held through reset release.
        do_reset();
        width_cfg = 6'd8; dead_cfg = 6'd0;
        bar_in[27] = 1'b1; tick(); bar_in[27] = 1'b0; ticks(3);
        check("t6_mid_active", bo1[27], 1);
        reset_n = 1'b0; tick();
        check("t6_reset_drop", bo1[27], 0);
        bar_in[27] = 1'b1; tick(); reset_n = 1'b1;
        rises = 0; prv = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bo1[27] && !prv) rises++;
            prv = bo1[27];
        end
        check("t6_one_pulse", rises, 1);
        bar_in[27] = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 5) == 0) bar_in[ch] = ~bar_in[ch];
            inhibit = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) begin
                width_cfg = 6'($urandom_range(0, 7));
                dead_cfg  = 6'($urandom_range(0, 7));
            end
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1;
        ticks(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
